// File: rtl/k_counter.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : k_counter
// Description : Signed up/down K-counter for a digital PLL loop filter.
//               The phase-detector sign (dnUp) is synchronized, then walks a
//               signed count between -(K-1) and K-1 with K = 2^(kSel+3).
//               Reaching K-1 going up emits a one-cycle carry pulse and
//               reaching -(K-1) going down emits a one-cycle borrow pulse.
//               In both cases the count then restarts from zero.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module k_counter #(
  parameter int CNT_W       = 11,  // signed count width, must hold +/-1023
  parameter int SYNC_STAGES = 2    // flops synchronizing dnUp, at least 1
) (
  input  logic                    clk,
  input  logic                    reset,   // asynchronous, active low
  input  logic                    en,
  input  logic                    dnUp,    // 0 = count up, 1 = count down
  input  logic [2:0]              kSel,    // K = 2^(kSel+3)
  output logic                    carry,
  output logic                    borrow,
  output logic signed [CNT_W-1:0] count
);

  // Magnitude arithmetic is one bit wider than the count so that K = 1024
  // and |count| compare without overflowing the count width.
  localparam int c_ext_w = CNT_W + 1;
  localparam logic [c_ext_w-1:0] c_ext_one = {{(c_ext_w-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]   c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [SYNC_STAGES-1:0]  sync_q;
  logic [SYNC_STAGES-1:0]  sync_d;
  logic [2:0]              kreg_q;
  logic [2:0]              kreg_d;
  logic signed [CNT_W-1:0] count_q;
  logic signed [CNT_W-1:0] count_d;
  logic                    carry_q;
  logic                    carry_d;
  logic                    borrow_q;
  logic                    borrow_d;

  logic                    w_dir_s;
  logic [3:0]              w_shift;
  logic [c_ext_w-1:0]      w_k_mag;
  logic [c_ext_w-1:0]      w_k_max;
  logic [c_ext_w-1:0]      w_k_min;
  logic [c_ext_w-1:0]      w_cnt_ext;
  logic [c_ext_w-1:0]      w_cnt_abs;
  logic                    w_at_top;
  logic                    w_at_bottom;
  logic                    w_out_of_range;

  // Synchronizer shift: dnUp enters stage 0 and the last stage is dirS.
  generate
    if (SYNC_STAGES == 1) begin : g_sync_single
      always_comb begin
        sync_d = dnUp;
      end
    end else begin : g_sync_chain
      always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], dnUp};
      end
    end
  endgenerate

  assign w_dir_s = sync_q[SYNC_STAGES-1];

  // Modulus register: the sampled kSel is the only source of K.
  always_comb begin
    kreg_d = kSel;
  end

  // Modulus decode and range comparisons for the current count.
  always_comb begin
    w_shift        = {1'b0, kreg_q} + 4'd3;
    w_k_mag        = c_ext_one << w_shift;
    w_k_max        = w_k_mag - c_ext_one;
    w_k_min        = ~w_k_max + c_ext_one;
    w_cnt_ext      = {count_q[CNT_W-1], count_q};
    w_cnt_abs      = count_q[CNT_W-1] ? (~w_cnt_ext + c_ext_one) : w_cnt_ext;
    // Only reachable right after K shrinks below the present magnitude.
    w_out_of_range = (w_cnt_abs >= w_k_mag);
    w_at_top       = (w_cnt_ext == w_k_max);
    w_at_bottom    = (w_cnt_ext == w_k_min);
  end

  // Count walk: range clear wins, then enable, then per-cycle direction.
  always_comb begin
    count_d  = count_q;
    carry_d  = 1'b0;
    borrow_d = 1'b0;
    if (w_out_of_range) begin
      // Silent clear when a smaller K no longer contains the count.
      count_d = '0;
    end else if (en) begin
      if (!w_dir_s) begin
        if (w_at_top) begin
          count_d = '0;
          carry_d = 1'b1;
        end else begin
          count_d = count_q + c_cnt_one;
        end
      end else begin
        if (w_at_bottom) begin
          count_d  = '0;
          borrow_d = 1'b1;
        end else begin
          count_d = count_q - c_cnt_one;
        end
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q   <= '0;
      kreg_q   <= '0;
      count_q  <= '0;
      carry_q  <= 1'b0;
      borrow_q <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      kreg_q   <= kreg_d;
      count_q  <= count_d;
      carry_q  <= carry_d;
      borrow_q <= borrow_d;
    end
  end

  assign carry  = carry_q;
  assign borrow = borrow_q;
  assign count  = count_q;

endmodule
`default_nettype wire

// File: doc/k_counter.md
K_COUNTER -- requirements
Module: k_counter

Interface
REQ-001 SHALL have parameter CNT_W, default 11, the signed count register width, sufficient for ±1023.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, the number of flip-flop stages synchronizing dnUp.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port en, input, 1 bit, synchronous: count enable.
REQ-006 SHALL have port dnUp, input, 1 bit, asynchronous: phase-detector error sign; 0 = count up, 1 = count down.
REQ-007 SHALL have port kSel, input, 3 bits, synchronous: modulus select, K = 2^(kSel+3), giving K = 8..1024.
REQ-008 SHALL have port carry, output, 1 bit, registered: single-cycle pulse feeding the downstream increment input.
REQ-009 SHALL have port borrow, output, 1 bit, registered: single-cycle pulse feeding the downstream decrement input.
REQ-010 SHALL have port count, output, CNT_W bits, registered, signed: current walk value.

Function
REQ-011 SHALL pass dnUp through SYNC_STAGES flip-flops, giving dirS; count logic SHALL use only dirS.
REQ-012 SHALL register kSel into kReg every cycle; kReg SHALL be the only modulus source, so a kSel change takes effect one cycle later.
REQ-013 SHALL hold count and drive carry = borrow = 0 when en = 0; the synchronizer SHALL keep running.
REQ-014 SHALL, with en = 1 and dirS = 0: if count == K-1, set count to 0 and carry to 1 in the next cycle; otherwise increment count by 1.
REQ-015 SHALL, with en = 1 and dirS = 1: if count == -(K-1), set count to 0 and borrow to 1 in the next cycle; otherwise decrement count by 1.
REQ-016 SHALL keep carry and borrow high for exactly one clk cycle per overflow or underflow event, and SHALL never assert both in the same cycle.
REQ-017 SHALL produce back-to-back carry pulses no closer than K cycles apart; the same rule SHALL apply to borrow.
REQ-018 SHALL, when kReg changes and |count| ≥ new K, clear count to 0 in that cycle without pulsing carry or borrow.
REQ-019 SHALL, when kReg changes and |count| < new K, continue counting from the current value.
REQ-020 SHALL have a latency of SYNC_STAGES+1 cycles from a dnUp edge to the first count change in the new direction.
REQ-021 SHALL perform all arithmetic in two's complement, CNT_W bits; count SHALL never leave the range [-(K-1), K-1].
REQ-022 SHALL have no state machine beyond the counter; direction is a per-cycle decision and no simultaneous up/down condition exists.

Reset
REQ-023 SHALL, when reset = 0, asynchronously force count = 0, carry = 0, borrow = 0, all synchronizer stages = 0, and kReg = 0.
REQ-024 SHALL, when reset is asserted mid-count, discard any pending pulse; after release, counting SHALL restart from 0 on the first rising clk edge.
REQ-025 SHALL deassert reset asynchronously; the release is synchronized externally to clk.

Verification
REQ-026 SHALL be verified with kSel = 0, en = 1, dnUp = 0: count steps 0..7, then carry = 1 for one cycle with count = 0; carry repeats every 8 cycles.
REQ-027 SHALL be verified with kSel = 1, dnUp = 1: count steps 0..-15, then borrow pulses once; borrow repeats every 16 cycles; carry stays 0.
REQ-028 SHALL be verified with dnUp alternating every 4 cycles at kSel = 0: count oscillates within ±4; carry and borrow never assert.
REQ-029 SHALL be verified with kSel changed from 3 to 0 at count = 40: count = 0 one cycle after kReg updates, no pulse; with kSel changed from 0 to 3 at count = 5, counting continues to 63 before carry.
REQ-030 SHALL be verified with en dropped for 10 cycles at count = 6 (K = 8): count holds at 6, no carry; carry fires 2 cycles after en returns.
REQ-031 SHALL be verified with reset pulsed low at count = -5: count = 0 and borrow = 0 immediately, without waiting for a clock; after release, counting resumes from 0.
